jtag_dtm_sampler: RTL and testbench
===================================

Name: jtag_dtm_sampler

Overview:
- JTAG debug transport for riscv_soc, driven by the jtag_pin_TCK/TMS/TDI/TDO pins.
- Oversamples the JTAG pins in the system clock domain and runs an IEEE 1149.1 TAP state machine.
- Turns MEMACC data-register updates into single-word memory read/write requests on the SoC memory bus (RAM/ROM side).
- Gives the bench and debugger a way to load and inspect memory without hierarchical preloading.

Parameters:
IDCODE, 32'h1000_0001, value captured by the IDCODE DR (bit0 must be 1)
IR_W, 5, instruction register width
SYNC_STAGES, 2, synchroniser depth for TCK/TMS/TDI

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
jtag_pin_TCK  in  1  JTAG clock (asynchronous, oversampled)
jtag_pin_TMS  in  1  JTAG mode select
jtag_pin_TDI  in  1  JTAG data in
jtag_pin_TDO  out  1  JTAG data out
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write, 0 = read
mem_addr  out  32  word-aligned byte address
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid with mem_ack
mem_ack  in  1  request complete (one clk pulse)

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous and active-low (rstn). Every register clears on rstn=0.
- Reset values: jtag_pin_TDO=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, TAP in Test-Logic-Reset, IR=5'h01, read-data latch=0, sticky overrun=0.
- Pin synchronisation: TCK, TMS and TDI each pass through SYNC_STAGES flops.
  - tck_rise = sync TCK 1 and previous 0; tck_fall = the opposite.
  - TCK high and low phases must each be ≥3 clk periods. Shorter pulses are unsupported.
- TAP state machine: the 16 IEEE 1149.1 states. Advances only on tck_rise, using the synced TMS.
  - Five consecutive TMS=1 rises reach Test-Logic-Reset from any state.
  - Test-Logic-Reset forces IR=5'h01.
- Instruction register:
  - Capture-IR loads 5'b00001 into the IR shift register.
  - Shift-IR shifts right on tck_rise, TDI into the MSB.
  - Update-IR copies the shift register into IR.
- DR selection by IR: 5'h01 selects IDCODE (32 b). 5'h11 selects MEMACC (66 b). Every other code selects BYPASS (1 b, captures 0).
- MEMACC DR layout: [1:0] op, [33:2] data, [65:34] addr.
  - Capture-DR loads op={sticky_overrun, busy}, data=read-data latch, addr=current mem_addr.
- Update-DR on MEMACC, by op value:
  - 00: no-op; also clears sticky_overrun.
  - 01: read of addr.
  - 10: write of data to addr.
  - 11: no-op.
  - If busy (mem_req=1) at Update-DR, op 01/10 is dropped and sticky_overrun is set.
- Memory handshake:
  - An accepted op drives mem_req=1 with mem_addr/mem_we/mem_wdata on the next clk.
  - These stay stable until a cycle with mem_ack=1. mem_req deasserts on the following clk.
  - On a read, mem_rdata is latched in the ack cycle.
  - mem_ack while mem_req=0 is ignored.
  - Latency is one clk from Update-DR to mem_req, ≥1 clk waiting for ack.
- TDO:
  - Updated on tck_fall with the LSB of the active shift register while in Shift-IR or Shift-DR.
  - Held in all other states.
  - The DR shift register shifts on tck_rise in Shift-DR, TDI into the MSB.
- Boundaries:
  - Test-Logic-Reset mid-transaction does not abort an outstanding request; it completes normally.
  - rstn low mid-transaction drops mem_req immediately.
  - Simultaneous mem_ack and Update-DR: the ack completes first. The new op is accepted (not overrun) and issues on the next clk.

Test Plan:
- rstn low, then five TMS=1 TCK cycles, Shift-DR 32 bits with no IR change -> TDO shifts out 32'h1000_0001 LSB first.
- Load IR 5'h11, shift {addr=32'h0000_0100, data=32'hDEADBEEF, op=2'b10}, Update-DR, ack after 3 clk -> exactly one mem_req with we=1, addr=0x100, wdata=0xDEADBEEF. mem_req deasserts the clk after ack.
- MEMACC read op=01 addr=0x100, ack with rdata=0x12345678, then Capture/Shift-DR -> op field 00, data field 0x12345678.
- Issue a write, hold mem_ack low, issue a second write -> second write dropped. Next capture op=2'b11. After ack, capture op=2'b10. Update op=00 -> capture op=2'b00.
- IR=5'h1f (BYPASS): shift pattern 1011 on TDI -> same pattern on TDO delayed by one TCK.
- Assert rstn=0 during mem_req=1 -> mem_req=0 and TDO=0 immediately. After release, the TAP is in Test-Logic-Reset and IR=5'h01.

Source files
------------

// File: rtl/jtag_dtm_sampler.sv
// JTAG debug transport: oversamples TCK/TMS/TDI in the clk domain, runs the 1149.1 TAP
// and turns MEMACC data-register updates into single-word memory bus requests.
module jtag_dtm_sampler #(
  parameter logic [31:0] IDCODE      = 32'h1000_0001,
  parameter int          IR_W        = 5,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        jtag_pin_TCK,
  input  logic        jtag_pin_TMS,
  input  logic        jtag_pin_TDI,
  output logic        jtag_pin_TDO,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(1);
  localparam logic [IR_W-1:0] IR_MEMACC = IR_W'(17);
  localparam int              DR_W      = 66;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_MEMACC
  } dr_sel_e;

  logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
  logic                   tck_prev;
  logic                   tck_s, tms_s, tdi_s;
  logic                   tck_rise, tck_fall;

  tap_state_e             state, state_next;
  dr_sel_e                dr_sel;
  logic [IR_W-1:0]        ir, ir_sr;
  logic [DR_W-1:0]        dr_sr;
  logic [31:0]            rd_latch;
  logic                   sticky_overrun;
  logic                   upd_memacc;
  logic [1:0]             upd_op;
  logic                   busy;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // blocking here would make the synchroniser chain collapse into a single stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_prev <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[SYNC_STAGES-2:0], jtag_pin_TCK};
      tms_sync <= {tms_sync[SYNC_STAGES-2:0], jtag_pin_TMS};
      tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], jtag_pin_TDI};
      tck_prev <= tck_s;
    end
  end

  assign tck_s    = tck_sync[SYNC_STAGES-1];
  assign tms_s    = tms_sync[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_prev;
  assign tck_fall = ~tck_s & tck_prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= TLR;
    else       state <= state_next;
  end

  // NOTE: the default assignment first keeps this block purely combinational (no latch)
  // for every state and for cycles without a TCK rise.
  always_comb begin
    state_next = state;
    if (tck_rise) begin
      case (state)
        TLR:      state_next = tms_s ? TLR      : RTI;
        RTI:      state_next = tms_s ? SEL_DR   : RTI;
        SEL_DR:   state_next = tms_s ? SEL_IR   : CAP_DR;
        CAP_DR:   state_next = tms_s ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR: state_next = tms_s ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR: state_next = tms_s ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: state_next = tms_s ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR: state_next = tms_s ? UPD_DR   : SHIFT_DR;
        UPD_DR:   state_next = tms_s ? SEL_DR   : RTI;
        SEL_IR:   state_next = tms_s ? TLR      : CAP_IR;
        CAP_IR:   state_next = tms_s ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR: state_next = tms_s ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR: state_next = tms_s ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: state_next = tms_s ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR: state_next = tms_s ? UPD_IR   : SHIFT_IR;
        UPD_IR:   state_next = tms_s ? SEL_DR   : RTI;
        default:  state_next = TLR;
      endcase
    end
  end

  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir == IR_IDCODE)      dr_sel = DR_IDCODE;
    else if (ir == IR_MEMACC) dr_sel = DR_MEMACC;
  end

  // Update actions take effect on the falling TCK edge while in the Update state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ir    <= IR_IDCODE;
      ir_sr <= '0;
    end else begin
      if (state == TLR)                     ir <= IR_IDCODE;
      else if (tck_fall && state == UPD_IR) ir <= ir_sr;
      if (tck_rise) begin
        case (state)
          CAP_IR:   ir_sr <= IR_W'(1);
          SHIFT_IR: ir_sr <= {tdi_s, ir_sr[IR_W-1:1]};
          default:  ;
        endcase
      end
    end
  end

  // Each DR shifts TDI into its own MSB so the chain length matches the selected register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dr_sr <= '0;
    end else if (tck_rise) begin
      if (state == CAP_DR) begin
        case (dr_sel)
          DR_IDCODE: dr_sr <= {34'b0, IDCODE};
          DR_MEMACC: dr_sr <= {mem_addr, rd_latch, sticky_overrun, mem_req};
          default:   dr_sr <= '0;
        endcase
      end else if (state == SHIFT_DR) begin
        case (dr_sel)
          DR_IDCODE: dr_sr <= {34'b0, tdi_s, dr_sr[31:1]};
          DR_MEMACC: dr_sr <= {tdi_s, dr_sr[DR_W-1:1]};
          default:   dr_sr <= {65'b0, tdi_s};
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      jtag_pin_TDO <= 1'b0;
    end else if (tck_fall) begin
      if (state == SHIFT_IR)      jtag_pin_TDO <= ir_sr[0];
      else if (state == SHIFT_DR) jtag_pin_TDO <= dr_sr[0];
    end
  end

  assign upd_memacc = tck_fall && (state == UPD_DR) && (dr_sel == DR_MEMACC);
  assign upd_op     = dr_sr[1:0];
  // An ack in the same cycle frees the bus, so a coinciding update is not an overrun.
  assign busy       = mem_req & ~mem_ack;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      rd_latch       <= '0;
      sticky_overrun <= 1'b0;
    end else begin
      if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
        if (!mem_we) rd_latch <= mem_rdata;
      end
      if (upd_memacc) begin
        case (upd_op)
          2'b00: sticky_overrun <= 1'b0;
          2'b01, 2'b10: begin
            if (busy) begin
              sticky_overrun <= 1'b1;
            end else begin
              mem_req  <= 1'b1;
              mem_we   <= upd_op[1];
              mem_addr <= dr_sr[65:34];
              if (upd_op[1]) mem_wdata <= dr_sr[33:2];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtag_dtm_sampler.sv
// Self-checking bench for jtag_dtm_sampler: drives JTAG sequences, models the memory
// slave and checks captured DR contents and bus transactions against a reference memory.
module tb_jtag_dtm_sampler;

  localparam logic [31:0] IDCODE = 32'h1000_0001;
  localparam int          HALF   = 5;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        jtag_pin_TCK = 1'b0;
  logic        jtag_pin_TMS = 1'b0;
  logic        jtag_pin_TDI = 1'b0;
  logic        jtag_pin_TDO;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtag_dtm_sampler #(.IDCODE(IDCODE), .IR_W(5), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn),
    .jtag_pin_TCK(jtag_pin_TCK), .jtag_pin_TMS(jtag_pin_TMS),
    .jtag_pin_TDI(jtag_pin_TDI), .jtag_pin_TDO(jtag_pin_TDO),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // ---------------- memory slave model ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        log_q[$];
  logic [31:0] mem_store [logic [31:0]];
  logic        hold_ack = 1'b0;
  logic        spurious = 1'b0;
  int          ack_delay = 0;
  int          req_rises = 0;
  int          stab_err = 0;
  int          drop_err = 0;

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  initial begin
    int          wait_cnt;
    logic        prev_req, prev_ack;
    logic [64:0] prev_bus;
    wait_cnt = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_bus = '0;
    forever begin
      @(negedge clk);
      if (prev_ack && prev_req && mem_req) drop_err++;
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        if (!prev_req || prev_ack) begin
          req_rises++;
          wait_cnt = 0;
        end else if ({mem_we, mem_addr, mem_wdata} !== prev_bus) begin
          stab_err++;
        end
        if (!hold_ack && wait_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) mem_store[mem_addr] = mem_wdata;
          else mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : default_word(mem_addr);
          log_q.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
        end else begin
          wait_cnt++;
        end
      end else if (spurious) begin
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
      end
      prev_req = (mem_req === 1'b1);
      prev_ack = mem_ack;
      prev_bus = {mem_we, mem_addr, mem_wdata};
    end
  end

  // ---------------- reference memory ----------------
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_rd = '0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : default_word(a);
  endfunction

  initial begin
    #900_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- JTAG drivers ----------------
  task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
    jtag_pin_TMS = tms_v;
    jtag_pin_TDI = tdi_v;
    repeat (HALF) @(negedge clk);
    tdo_v = jtag_pin_TDO;
    jtag_pin_TCK = 1'b1;
    repeat (HALF) @(negedge clk);
    jtag_pin_TCK = 1'b0;
  endtask

  task automatic tap_reset();
    logic d;
    repeat (5) tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
  endtask

  task automatic shift_ir(input logic [4:0] v, output logic [4:0] cap);
    logic d;
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    for (int i = 0; i < 5; i++) tck_cycle(i == 4, v[i], cap[i]);
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
  endtask

  task automatic shift_dr(input logic [65:0] din, input int n, output logic [65:0] dout);
    logic d;
    dout = '0;
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], d);
      dout[i] = d;
    end
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
  endtask

  task automatic memacc(input logic [31:0] a, input logic [31:0] dat, input logic [1:0] op,
                        output logic [65:0] cap);
    shift_dr({a, dat, op}, 66, cap);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (mem_req === 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle mem_req=%b exp=0 after %0d clk", name, mem_req, t);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (jtag_pin_TDO !== 1'b0) begin errors++; $display("FAIL reset_tdo got=%b exp=0", jtag_pin_TDO); end
    checks++; if (mem_req !== 1'b0)      begin errors++; $display("FAIL reset_req got=%b exp=0", mem_req); end
    checks++; if (mem_we !== 1'b0)       begin errors++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 32'h0)    begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0)   begin errors++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_idcode();
    logic [65:0] cap;
    tap_reset();
    shift_dr('0, 32, cap);
    checks++;
    if (cap[31:0] !== IDCODE) begin errors++; $display("FAIL idcode got=%h exp=%h", cap[31:0], IDCODE); end
  endtask

  task automatic test_write();
    logic [4:0]  ircap;
    logic [65:0] cap;
    int          r0, n0;
    shift_ir(5'h11, ircap);
    checks++;
    if (ircap !== 5'b00001) begin errors++; $display("FAIL ir_capture got=%b exp=00001", ircap); end
    ack_delay = 3;
    r0 = req_rises; n0 = log_q.size();
    memacc(32'h0000_0100, 32'hDEAD_BEEF, 2'b10, cap);
    wait_idle("write");
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    checks++;
    if (req_rises - r0 !== 1) begin errors++; $display("FAIL write_req_count got=%0d exp=1", req_rises - r0); end
    checks++;
    if (log_q.size() !== n0 + 1) begin
      errors++; $display("FAIL write_txn_count got=%0d exp=%0d", log_q.size(), n0 + 1);
    end else if (log_q[$].we !== 1'b1 || log_q[$].addr !== 32'h100 || log_q[$].wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL write_txn got we=%b addr=%h wdata=%h exp we=1 addr=00000100 wdata=deadbeef",
                         log_q[$].we, log_q[$].addr, log_q[$].wdata);
    end
  endtask

  task automatic test_read();
    logic [65:0] cap;
    mem_store[32'h100] = 32'h1234_5678;
    ref_mem[32'h100]   = 32'h1234_5678;
    ack_delay = 1;
    memacc(32'h0000_0100, 32'h0, 2'b01, cap);
    wait_idle("read");
    exp_rd = ref_read(32'h100);
    checks++;
    if (log_q.size() == 0 || log_q[$].we !== 1'b0 || log_q[$].addr !== 32'h100) begin
      errors++; $display("FAIL read_txn queue=%0d exp a read of 00000100", log_q.size());
    end
    memacc(32'h0, 32'h0, 2'b11, cap);
    checks++; if (cap[1:0] !== 2'b00)  begin errors++; $display("FAIL read_op got=%b exp=00", cap[1:0]); end
    checks++; if (cap[33:2] !== exp_rd) begin errors++; $display("FAIL read_data got=%h exp=%h", cap[33:2], exp_rd); end
    checks++; if (cap[65:34] !== 32'h100) begin errors++; $display("FAIL read_addr got=%h exp=00000100", cap[65:34]); end
  endtask

  task automatic test_overrun();
    logic [65:0] cap;
    int          n0;
    n0 = log_q.size();
    hold_ack = 1'b1;
    memacc(32'h200, 32'hA1A1_0001, 2'b10, cap);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL ovr_req_held got=%b exp=1", mem_req); end
    memacc(32'h204, 32'hB2B2_0002, 2'b10, cap);
    memacc(32'h0, 32'h0, 2'b11, cap);
    checks++; if (cap[1:0] !== 2'b11) begin errors++; $display("FAIL ovr_op_busy got=%b exp=11", cap[1:0]); end
    checks++; if (cap[65:34] !== 32'h200) begin errors++; $display("FAIL ovr_addr got=%h exp=00000200", cap[65:34]); end
    hold_ack = 1'b0;
    wait_idle("overrun");
    ref_mem[32'h200] = 32'hA1A1_0001;
    checks++;
    if (log_q.size() !== n0 + 1 || log_q[$].addr !== 32'h200 || log_q[$].wdata !== 32'hA1A1_0001) begin
      errors++; $display("FAIL ovr_txn count=%0d exp=%0d (only the first write)", log_q.size(), n0 + 1);
    end
    memacc(32'h0, 32'h0, 2'b00, cap);
    checks++; if (cap[1:0] !== 2'b10) begin errors++; $display("FAIL ovr_op_sticky got=%b exp=10", cap[1:0]); end
    memacc(32'h0, 32'h0, 2'b11, cap);
    checks++; if (cap[1:0] !== 2'b00) begin errors++; $display("FAIL ovr_op_cleared got=%b exp=00", cap[1:0]); end
  endtask

  task automatic test_bypass();
    logic [4:0]  ircap;
    logic [65:0] cap;
    logic [65:0] din;
    int          r0;
    r0  = req_rises;
    din = '0;
    din[3:0] = 4'b1101;
    shift_ir(5'h1f, ircap);
    shift_dr(din, 5, cap);
    checks++; if (cap[0] !== 1'b0) begin errors++; $display("FAIL bypass_capture got=%b exp=0", cap[0]); end
    checks++; if (cap[4:1] !== din[3:0]) begin errors++; $display("FAIL bypass_delay got=%b exp=%b", cap[4:1], din[3:0]); end
    checks++; if (req_rises !== r0) begin errors++; $display("FAIL bypass_no_req got=%0d exp=%0d", req_rises, r0); end
  endtask

  task automatic test_spurious_ack();
    logic [4:0]  ircap;
    logic [65:0] cap;
    int          n0;
    n0 = log_q.size();
    shift_ir(5'h11, ircap);
    spurious = 1'b1;
    repeat (20) @(negedge clk);
    spurious = 1'b0;
    memacc(32'h0, 32'h0, 2'b11, cap);
    checks++; if (cap[33:2] !== exp_rd) begin errors++; $display("FAIL spurious_data got=%h exp=%h", cap[33:2], exp_rd); end
    checks++; if (cap[1:0] !== 2'b00) begin errors++; $display("FAIL spurious_op got=%b exp=00", cap[1:0]); end
    checks++; if (log_q.size() !== n0) begin errors++; $display("FAIL spurious_txn got=%0d exp=%0d", log_q.size(), n0); end
  endtask

  task automatic test_random();
    logic [65:0] cap;
    logic [31:0] a, d;
    int          n0;
    for (int k = 0; k < 12; k++) begin
      a = 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4;
      ack_delay = $urandom_range(0, 5);
      n0 = log_q.size();
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        memacc(a, d, 2'b10, cap);
        wait_idle("rnd_write");
        ref_mem[a] = d;
        checks++;
        if (log_q.size() !== n0 + 1) begin
          errors++; $display("FAIL rnd_write_count got=%0d exp=%0d", log_q.size(), n0 + 1);
        end else if (log_q[$].we !== 1'b1 || log_q[$].addr !== a || log_q[$].wdata !== d) begin
          errors++; $display("FAIL rnd_write_txn got we=%b addr=%h wdata=%h exp we=1 addr=%h wdata=%h",
                             log_q[$].we, log_q[$].addr, log_q[$].wdata, a, d);
        end
      end else begin
        memacc(a, $urandom, 2'b01, cap);
        wait_idle("rnd_read");
        exp_rd = ref_read(a);
        memacc(32'h0, 32'h0, 2'b11, cap);
        checks++; if (cap[33:2] !== exp_rd) begin errors++; $display("FAIL rnd_read_data addr=%h got=%h exp=%h", a, cap[33:2], exp_rd); end
        checks++; if (cap[65:34] !== a) begin errors++; $display("FAIL rnd_read_addr got=%h exp=%h", cap[65:34], a); end
        checks++; if (cap[1:0] !== 2'b00) begin errors++; $display("FAIL rnd_read_op got=%b exp=00", cap[1:0]); end
      end
    end
  endtask

  task automatic test_tlr_midflight();
    logic [4:0]  ircap;
    logic [65:0] cap;
    shift_ir(5'h11, ircap);
    ack_delay = 0;
    hold_ack  = 1'b1;
    memacc(32'h300, 32'hC3C3_0003, 2'b10, cap);
    tap_reset();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL tlr_req_kept got=%b exp=1", mem_req); end
    shift_dr('0, 32, cap);
    checks++; if (cap[31:0] !== IDCODE) begin errors++; $display("FAIL tlr_ir_idcode got=%h exp=%h", cap[31:0], IDCODE); end
    hold_ack = 1'b0;
    wait_idle("tlr");
    ref_mem[32'h300] = 32'hC3C3_0003;
    checks++;
    if (log_q.size() == 0 || log_q[$].addr !== 32'h300 || log_q[$].wdata !== 32'hC3C3_0003) begin
      errors++; $display("FAIL tlr_txn queue=%0d exp write of c3c30003 to 00000300", log_q.size());
    end
  endtask

  task automatic test_async_reset();
    logic [4:0]  ircap;
    logic [65:0] cap;
    logic        d;
    shift_ir(5'h11, ircap);
    hold_ack = 1'b1;
    memacc(32'h400, 32'hD4D4_0004, 2'b10, cap);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL arst_req_before got=%b exp=1", mem_req); end
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL arst_req got=%b exp=0", mem_req); end
    checks++; if (jtag_pin_TDO !== 1'b0) begin errors++; $display("FAIL arst_tdo got=%b exp=0", jtag_pin_TDO); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL arst_addr got=%h exp=0", mem_addr); end
    hold_ack = 1'b0;
    exp_rd   = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    tck_cycle(1'b0, 1'b0, d);
    shift_dr('0, 32, cap);
    checks++; if (cap[31:0] !== IDCODE) begin errors++; $display("FAIL arst_idcode got=%h exp=%h", cap[31:0], IDCODE); end
    shift_ir(5'h11, ircap);
    memacc(32'h0, 32'h0, 2'b11, cap);
    checks++; if (cap !== 66'h0) begin errors++; $display("FAIL arst_memacc got=%h exp=0", cap); end
  endtask

  task automatic test_stability();
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL bus_stable got=%0d changes exp=0", stab_err); end
    checks++; if (drop_err !== 0) begin errors++; $display("FAIL req_drop_after_ack got=%0d late exp=0", drop_err); end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_write();
    test_read();
    test_overrun();
    test_bypass();
    test_spurious_ack();
    test_random();
    test_tlr_midflight();
    test_async_reset();
    test_stability();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
